// File: rtl/fmac_pkg.sv
// Shared types and width helpers for the float64 MAC row sequencer.
package fmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fmac_state_e;

    localparam int FP_W = 64;

    // Index width for n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // LSB of element j in a flat vector of w-bit elements.
    function automatic int elem_lsb(input int j, input int w);
        return j * w;
    endfunction

endpackage

// File: rtl/fmac_credit_ctr.sv
// Counts rows issued to the MAC chain whose sums have not yet returned.
// A decrement at zero is dropped and reported as an overflow pulse.
module fmac_credit_ctr
    import fmac_pkg::*;
#(
    parameter int MAX_OUT = 4,
    localparam int CW = cnt_w(MAX_OUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf
);

    logic [CW-1:0] count_q, count_d;
    logic          dec_ok;

    assign dec_ok = dec && (count_q != '0);

    // Next count: simultaneous inc and accepted dec cancel out.
    always_comb begin
        count_d = count_q;
        if (inc && !dec_ok)
            count_d = count_q + 1'b1;
        else if (!inc && dec_ok)
            count_d = count_q - 1'b1;
    end

    // Credit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign full  = (count_q == CW'(MAX_OUT));
    assign empty = (count_q == '0);
    assign ovf   = dec && (count_q == '0);

endmodule

// File: rtl/fmac_row_sched.sv
// Sequencer for the shared float64 MAC chain computing F = H*x: accepts I
// rows of J coefficients, issues (coefficient, x) pairs with a per-row last
// flag, limits rows in flight, and returns indexed row sums.
module fmac_row_sched
    import fmac_pkg::*;
#(
    parameter int J       = 14,
    parameter int I       = 7,
    parameter int A       = 2,
    parameter int MAX_OUT = 4,
    localparam int AWIDTH = $clog2(A) + 1,
    localparam int JW     = idx_w(J),
    localparam int IW     = idx_w(I),
    localparam int CW     = cnt_w(MAX_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [J*AWIDTH-1:0]   x,
    output logic                  busy,
    output logic                  done,
    input  logic [J*FP_W-1:0]     H_row,
    input  logic                  H_row_valid,
    output logic                  H_row_ready,
    output logic [FP_W-1:0]       elem_H,
    output logic [AWIDTH-1:0]     elem_x,
    output logic                  elem_valid,
    output logic                  elem_last,
    input  logic                  elem_ready,
    input  logic [FP_W-1:0]       res_data,
    input  logic                  res_valid,
    input  logic                  res_last,
    output logic [FP_W-1:0]       F_out,
    output logic                  F_out_valid,
    output logic [IW-1:0]         F_out_idx,
    output logic                  err_overflow
);

    // Row and result counters must reach I itself.
    localparam int RW = cnt_w(I);

    fmac_state_e           state_q;
    logic [J*AWIDTH-1:0]   x_q;
    logic [J*FP_W-1:0]     row_q;
    logic [JW-1:0]         j_q;
    logic [RW-1:0]         rows_q;
    logic [RW-1:0]         res_q;
    logic                  busy_q, done_q, rdy_q;
    logic                  ev_q, el_q;
    logic [FP_W-1:0]       eh_q;
    logic [AWIDTH-1:0]     ex_q;
    logic [FP_W-1:0]       fo_q;
    logic                  fov_q;
    logic [IW-1:0]         foi_q;
    logic                  err_q;

    logic [FP_W-1:0]       row_e [J];
    logic [AWIDTH-1:0]     x_e   [J];
    logic [JW-1:0]         jn;
    logic                  elem_hs, last_hs, row_hs, sum_ok;
    logic                  cr_inc, cr_full, cr_empty, cr_ovf;
    logic [CW-1:0]         cr_count, cr_next;

    for (genvar g = 0; g < J; g++) begin : g_elem
        assign row_e[g] = row_q[elem_lsb(g, FP_W) +: FP_W];
        assign x_e[g]   = x_q[elem_lsb(g, AWIDTH) +: AWIDTH];
    end

    assign jn      = j_q + 1'b1;
    assign elem_hs = ev_q && elem_ready;
    assign last_hs = elem_hs && el_q;
    assign row_hs  = rdy_q && H_row_valid;
    // Only a tagged sum with a credit outstanding is a real row result.
    assign sum_ok  = res_valid && res_last && !cr_empty;
    assign cr_inc  = last_hs && !cr_full;
    // Credit value after this edge, so H_row_ready is correct the cycle it shows.
    assign cr_next = cr_count + CW'(cr_inc) - CW'(sum_ok);

    fmac_credit_ctr #(.MAX_OUT(MAX_OUT)) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cr_inc),
        .dec   (res_valid && res_last),
        .count (cr_count),
        .full  (cr_full),
        .empty (cr_empty),
        .ovf   (cr_ovf)
    );

    // Pass sequencing with registered handshake and element outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            row_q   <= '0;
            j_q     <= '0;
            rows_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
            ev_q    <= 1'b0;
            el_q    <= 1'b0;
            eh_q    <= '0;
            ex_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q     <= x;
                        rows_q  <= '0;
                        busy_q  <= 1'b1;
                        rdy_q   <= (cr_next < CW'(MAX_OUT));
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rdy_q <= (cr_next < CW'(MAX_OUT));
                    if (row_hs) begin
                        row_q   <= H_row;
                        j_q     <= '0;
                        eh_q    <= H_row[FP_W-1:0];
                        ex_q    <= x_e[0];
                        ev_q    <= 1'b1;
                        el_q    <= (J == 1);
                        rdy_q   <= 1'b0;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (elem_hs) begin
                        if (el_q) begin
                            ev_q   <= 1'b0;
                            el_q   <= 1'b0;
                            rows_q <= rows_q + 1'b1;
                            if (rows_q + 1'b1 < RW'(I)) begin
                                rdy_q   <= (cr_next < CW'(MAX_OUT));
                                state_q <= ST_LOAD;
                            end else begin
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            j_q  <= jn;
                            eh_q <= row_e[jn];
                            ex_q <= x_e[jn];
                            el_q <= (jn == JW'(J - 1));
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cr_empty && res_q == RW'(I)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Result capture, row indexing and sticky overflow; active in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            fo_q  <= '0;
            fov_q <= 1'b0;
            foi_q <= '0;
            err_q <= 1'b0;
        end else begin
            fov_q <= sum_ok;
            if (sum_ok) begin
                fo_q  <= res_data;
                foi_q <= res_q[IW-1:0];
            end
            if (state_q == ST_IDLE && start)
                res_q <= '0;
            else if (sum_ok)
                res_q <= res_q + 1'b1;
            if (cr_ovf)
                err_q <= 1'b1;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign H_row_ready  = rdy_q;
    assign elem_H       = eh_q;
    assign elem_x       = ex_q;
    assign elem_valid   = ev_q;
    assign elem_last    = el_q;
    assign F_out        = fo_q;
    assign F_out_valid  = fov_q;
    assign F_out_idx    = foi_q;
    assign err_overflow = err_q;

endmodule
